mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Sequential front end that shares one 16x16 signed combinational multiplier (`Mul`, 32-bit product) between two requesters.
- Arbitrates incoming operand pairs round-robin and registers the operands into the shared `Mul`.
- Captures the 32-bit product and returns it on a single tagged response channel with a valid/ready handshake.
- Sits between the ALU issue logic and the `Mul` datapath; `Mul` is instantiated inside this block.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH. Only 16 is supported by `Mul`.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 handshake accepted this cycle
- req0_a  input  16  requester 0 multiplicand, signed
- req0_b  input  16  requester 0 multiplier, signed
- req1_valid  input  1  requester 1 has an operand pair
- req1_ready  output  1  requester 1 handshake accepted this cycle
- req1_a  input  16  requester 1 multiplicand, signed
- req1_b  input  16  requester 1 multiplier, signed
- resp_valid  output  1  product available
- resp_ready  input  1  consumer accepts product
- resp_id  output  1  id of the requester that owns the product
- resp_prod  output  32  signed product
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; resp_valid=0, resp_id=0, resp_prod=0, busy=0; operand regs=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, CALC, RESP.
- IDLE, grant logic (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = (state==IDLE) && granted N; the ready of the non-granted requester is 0.
  - reqN_ready must not depend on resp_ready.
- IDLE, on a handshake (valid & ready):
  - Latch a/b into op_a/op_b, id into op_id, and set last_grant=id.
  - Next state CALC. With no request, stay in IDLE.
- CALC: `Mul` sees op_a/op_b. Register its result into resp_prod and op_id into resp_id; next state RESP.
- RESP:
  - resp_valid=1; resp_prod and resp_id are held stable until the handshake.
  - On resp_valid & resp_ready, go to IDLE next cycle. Otherwise stay in RESP (backpressure is unbounded).
- Latency: request handshake at cycle k gives resp_valid=1 at cycle k+2.
  - Best case throughput is one operation per 3 cycles (handshake, CALC, RESP with resp_ready=1).
- No new request is accepted in CALC or RESP; both readys are 0. Requesters must hold valid and operands until their ready.
- Arithmetic: full signed 16x16 -> 32, no truncation or saturation. The product is exactly sign_ext(a)*sign_ext(b) mod 2^32.
  - 0x8000*0x8000 = 0x40000000.
- A requester dropping valid before being granted is legal; nothing is latched.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded, resp_valid drops immediately (async), and last_grant returns to 1.
- busy = (state != IDLE).

Test Plan:
1. Single request: req0 a=3, b=0xFFFB (-5), resp_ready=1. Handshake at cycle k, then resp_valid at k+2 with resp_prod=0xFFFFFFF1 and resp_id=0. Back in IDLE at k+3.
2. Simultaneous requests after reset: req0 (a=0x7FFF, b=0x8000) and req1 (a=0xFFFF, b=0xFFFF) held valid. Responses arrive in order id0 = 0xC0008000, then id1 = 0x00000001. req1_ready stays 0 until req0 has completed.
3. Round-robin fairness: both requesters valid continuously for 6 operations. Grants alternate 0,1,0,1,0,1 and neither requester is ever granted twice in a row.
4. Backpressure: resp_ready=0 for 5 cycles after resp_valid rises. resp_prod and resp_id stay stable, and req0_ready/req1_ready stay 0 throughout. Completion happens the cycle after resp_ready=1.
5. Extremes, one per op: 0x8000*0x8000 -> 0x40000000; 0x0000*0x1234 -> 0; 0x8000*0x0001 -> 0xFFFF8000. The bench compares each against the sign-extended 32-bit reference product.
6. Reset mid-op: assert rst_n=0 while in CALC. resp_valid=0 and busy=0 immediately. After release, the first tie is granted to req0.

Source files
------------

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin front end sharing one signed 16x16 multiplier
// between two requesters, with a single tagged valid/ready response channel.

// Combinational signed multiplier; full-precision product of two operands.
module mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);
  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;

  // Sign-extend to product width so the multiply is exact modulo 2^PW.
  always_comb begin
    a_ext = $signed({{WIDTH{a[WIDTH-1]}}, a});
    b_ext = $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod  = a_ext * b_ext;
  end
endmodule

module mul_share_arb #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [2*WIDTH-1:0]   resp_prod,
  output logic                 busy
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_id_q;
  logic [PW-1:0]    mul_prod;

  logic             gnt_any;
  logic             gnt_id;
  logic             take;
  logic             cap;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = req1_valid;
    end
    req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
    req1_ready = (state_q == IDLE) && req1_valid && gnt_id;
  end

  mul #(.WIDTH(WIDTH)) u_mul (
    .a    (op_a_q),
    .b    (op_b_q),
    .prod (mul_prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus operand-take and product-capture strobes.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          take    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        cap     = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, grant-history and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_prod    <= '0;
      resp_id      <= 1'b0;
      resp_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (take) begin
        op_a_q       <= gnt_id ? req1_a : req0_a;
        op_b_q       <= gnt_id ? req1_b : req0_b;
        op_id_q      <= gnt_id;
        last_grant_q <= gnt_id;
      end
      if (cap) begin
        resp_prod <= mul_prod;
        resp_id   <= op_id_q;
      end
      resp_valid <= (state_d == RESP);
      busy       <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb.
module tb_mul_share_arb;
  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_prod;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mul_share_arb #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: sign-extend both operands and multiply at 32 bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] ea;
    logic signed [31:0] eb;
    ea = $signed({{16{a[15]}}, a});
    eb = $signed({{16{b[15]}}, b});
    return 32'(ea * eb);
  endfunction

  // One complete operation from a single requester with resp_ready held high.
  task automatic do_op(input string tag, input logic id, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    int cyc;
    resp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    cyc = 0;
    while (!(id ? req1_ready : req0_ready) && cyc < 8) begin step(); cyc++; end
    check({tag, "_grant"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 8) begin step(); cyc++; end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    check({tag, "_prod"}, resp_prod, exp);
    check({tag, "_ref"}, resp_prod, ref_mul(a, b));
    check({tag, "_id"}, 32'(resp_id), 32'(id));
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_vdrop"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_id", 32'(resp_id), 32'd0);
    check("rst_prod", resp_prod, 32'd0);
    do_reset();

    // 1: single request, 3 * -5
    do_op("single", 1'b0, 16'd3, 16'hFFFB, 32'hFFFFFFF1);

    // 2: simultaneous requests right after reset; req0 wins the first tie
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h8000;
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
    #1;
    check("tie_r0", 32'(req0_ready), 32'd1);
    check("tie_r1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    check("tie_calc_r1", 32'(req1_ready), 32'd0);
    step();
    check("tie_resp0_v", 32'(resp_valid), 32'd1);
    check("tie_resp0_p", resp_prod, 32'hC0008000);
    check("tie_resp0_id", 32'(resp_id), 32'd0);
    check("tie_resp_r1", 32'(req1_ready), 32'd0);
    step();
    check("tie_r1_grant", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    check("tie_resp1_p", resp_prod, 32'h00000001);
    check("tie_resp1_id", 32'(resp_id), 32'd1);
    step();

    // 3: round-robin, both requesters continuously valid (last grant was 1)
    req0_valid = 1'b1; req0_a = 16'd2;    req0_b = 16'd3;
    req1_valid = 1'b1; req1_a = 16'hFFFE; req1_b = 16'd7;
    resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d_r0", i), 32'(req0_ready), 32'((i % 2) == 0));
      check($sformatf("rr%0d_r1", i), 32'(req1_ready), 32'((i % 2) == 1));
      step();
      step();
      check($sformatf("rr%0d_id", i), 32'(resp_id), 32'(i % 2));
      check($sformatf("rr%0d_p", i), resp_prod, ((i % 2) == 0) ? 32'd6 : 32'hFFFFFFF2);
      step();
    end
    req1_valid = 1'b0;

    // 4: backpressure for 5 cycles while req1 waits (last grant was 1 -> req0)
    resp_ready = 1'b0;
    req0_a = 16'h0100; req0_b = 16'h0100;
    req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd5;
    #1;
    check("bp_grant", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_v", i), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_p", i), resp_prod, 32'h00010000);
      check($sformatf("bp%0d_id", i), 32'(resp_id), 32'd0);
      check($sformatf("bp%0d_rdy", i), 32'({req0_ready, req1_ready}), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hold_v", 32'(resp_valid), 32'd1);
    step();
    check("bp_done_v", 32'(resp_valid), 32'd0);
    check("bp_done_r1", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;   // withdraw before any edge: nothing must be taken
    step();
    check("bp_withdraw", 32'(busy), 32'd0);

    // 5: extremes
    do_op("ext_min", 1'b0, 16'h8000, 16'h8000, 32'h40000000);
    do_op("ext_zero", 1'b1, 16'h0000, 16'h1234, 32'h00000000);
    do_op("ext_neg", 1'b0, 16'h8000, 16'h0001, 32'hFFFF8000);

    // 6: reset during CALC; last grant was 0 so only reset makes req0 win the next tie
    req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd9;
    #1;
    check("mid_grant", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    check("mid_calc_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req0_valid = 1'b1; req0_a = 16'd4; req0_b = 16'd4;
    req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1;
    #1;
    check("post_rst_r0", 32'(req0_ready), 32'd1);
    check("post_rst_r1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("post_rst_p", resp_prod, 32'd16);
    check("post_rst_id", 32'(resp_id), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
